// File: rtl/trdb_pkg.sv
// Shared packet encodings for the trace-encoder priority logic.
package trdb_pkg;

  typedef enum logic [1:0] {
    FMT_NONE = 2'b00,
    FMT_F1   = 2'b01,
    FMT_F2   = 2'b10,
    FMT_F3   = 2'b11
  } format_e;

  typedef enum logic [1:0] {
    SF_SYNC    = 2'b00,
    SF_TRAP    = 2'b01,
    SF_SUPPORT = 2'b11
  } f_sync_subformat_e;

  typedef enum logic [1:0] {
    QS_NO_CHANGE = 2'b00,
    QS_ENDED_REP = 2'b01,
    QS_ENDED_NTR = 2'b11
  } qual_status_e;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned KEEP_W = 5;

endpackage

// File: rtl/trdb_lsb_count.sv
// Counts how many address bits are needed once the redundant leading sign
// bits are dropped: keep_bits = 32 - (length of the run matching bit 31).
module trdb_lsb_count
  import trdb_pkg::*;
(
  input  logic [ADDR_W-1:0] value,
  output logic [KEEP_W-1:0] keep_bits
);

  // run[i] is set while every bit from 30 down to i still matches bit 31
  logic [ADDR_W-2:0] run;

  assign run[ADDR_W-2] = (value[ADDR_W-2] == value[ADDR_W-1]);

  generate
    for (genvar gi = 0; gi < ADDR_W - 2; gi++) begin : g_run
      assign run[gi] = run[gi+1] & (value[gi] == value[ADDR_W-1]);
    end
  endgenerate

  always_comb begin
    keep_bits = 5'd31;
    for (int i = 0; i < ADDR_W - 1; i++) begin
      keep_bits = keep_bits - {4'd0, run[i]};
    end
  end

endmodule

// File: rtl/trdb_priority.sv
// Decides whether the trace encoder must emit a packet this cycle, which
// format it takes, and tracks whether qualification ended on a repetition.
module trdb_priority
  import trdb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic              lc_exception_i,
  input  logic              lc_updiscon_i,
  input  logic              lc_final_qualified_i,
  input  logic              tc_qualified_i,
  input  logic              tc_exception_i,
  input  logic              tc_retired_i,
  input  logic              tc_first_qualified_i,
  input  logic              tc_privchange_i,
  input  logic              tc_gt_max_resync_i,
  input  logic              tc_et_max_resync_i,
  input  logic              tc_branch_map_empty_i,
  input  logic              tc_branch_map_full_i,
  input  logic              tc_enc_enabled_i,
  input  logic              tc_enc_disabled_i,
  input  logic              tc_opmode_change_i,
  input  logic              nc_exception_i,
  input  logic              nc_privchange_i,
  input  logic              nc_branch_map_empty_i,
  input  logic              nc_qualified_i,
  input  logic              nc_retired_i,
  input  logic [ADDR_W-1:0] addr_to_compress_i,
  output logic              valid_o,
  output logic [1:0]        packet_format_o,
  output logic [1:0]        packet_f_sync_subformat_o,
  output logic              thaddr_o,
  output logic              lc_tc_mux_o,
  output logic              resync_timer_rst_o,
  output logic [1:0]        qual_status_o,
  output logic [KEEP_W-1:0] keep_bits_o
);

  logic              rep_q;
  logic              rep_set;
  logic              rep_clr;
  format_e           fmt;
  f_sync_subformat_e subfmt;
  qual_status_e      qual;
  format_e           addr_fmt;
  logic              support_evt;
  logic              sync_evt;
  logic              next_break;

  // Reserved next-cycle hints, intentionally not used by the priority logic
  logic unused_reserved;
  assign unused_reserved = ^{nc_branch_map_empty_i, nc_retired_i, lc_final_qualified_i};

  assign support_evt = tc_enc_enabled_i | tc_enc_disabled_i | tc_opmode_change_i;
  assign sync_evt    = tc_first_qualified_i | tc_privchange_i
                     | (tc_et_max_resync_i & tc_branch_map_empty_i);
  assign next_break  = nc_exception_i | nc_privchange_i | ~nc_qualified_i;
  // An empty branch map needs no branch field, so the shorter F2 suffices
  assign addr_fmt    = tc_branch_map_empty_i ? FMT_F2 : FMT_F1;

  always_comb begin
    valid_o            = 1'b0;
    fmt                = FMT_NONE;
    subfmt             = SF_SYNC;
    thaddr_o           = 1'b0;
    lc_tc_mux_o        = 1'b0;
    resync_timer_rst_o = 1'b0;
    qual               = QS_NO_CHANGE;
    rep_set            = 1'b0;
    rep_clr            = 1'b0;
    if (valid_i) begin
      if (support_evt) begin
        valid_o = 1'b1;
        fmt     = FMT_F3;
        subfmt  = SF_SUPPORT;
        rep_clr = 1'b1;
        if (tc_enc_disabled_i) begin
          qual = rep_q ? QS_ENDED_REP : QS_ENDED_NTR;
        end
      end else if (tc_qualified_i) begin
        if (lc_exception_i) begin
          valid_o            = 1'b1;
          fmt                = FMT_F3;
          subfmt             = SF_TRAP;
          lc_tc_mux_o        = 1'b1;
          resync_timer_rst_o = 1'b1;
          thaddr_o           = ~(tc_exception_i & ~tc_retired_i);
        end else if (sync_evt) begin
          valid_o            = 1'b1;
          fmt                = FMT_F3;
          subfmt             = SF_SYNC;
          lc_tc_mux_o        = 1'b1;
          resync_timer_rst_o = 1'b1;
        end else if (lc_updiscon_i) begin
          valid_o     = 1'b1;
          fmt         = addr_fmt;
          lc_tc_mux_o = 1'b1;
        end else if (tc_gt_max_resync_i & ~tc_branch_map_empty_i) begin
          valid_o            = 1'b1;
          fmt                = addr_fmt;
          lc_tc_mux_o        = 1'b1;
          resync_timer_rst_o = 1'b1;
        end else if (tc_retired_i & next_break) begin
          valid_o     = 1'b1;
          fmt         = addr_fmt;
          lc_tc_mux_o = 1'b1;
          rep_set     = ~nc_qualified_i;
        end else if (tc_branch_map_full_i) begin
          valid_o = 1'b1;
          fmt     = FMT_F1;
        end
      end
    end
  end

  assign packet_format_o           = fmt;
  assign packet_f_sync_subformat_o = (fmt == FMT_F3) ? subfmt : SF_SYNC;
  assign qual_status_o             = qual;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_q <= 1'b0;
    end else if (rep_clr) begin
      rep_q <= 1'b0;
    end else if (rep_set) begin
      rep_q <= 1'b1;
    end
  end

  trdb_lsb_count u_lsb_count (
    .value     (addr_to_compress_i),
    .keep_bits (keep_bits_o)
  );

endmodule

// File: tb/tb_trdb_priority.sv
// Self-checking bench: directed cases plus randomized stimulus checked
// every cycle against a behavioural model of the packet priority rules.
module tb_trdb_priority;

  typedef struct packed {
    logic        valid;
    logic        lc_exc, lc_upd, lc_fq;
    logic        tc_q, tc_exc, tc_ret, tc_fq, tc_priv, tc_gt, tc_et;
    logic        tc_bme, tc_bmf, tc_en, tc_dis, tc_opm;
    logic        nc_exc, nc_priv, nc_bme, nc_q, nc_ret;
    logic [31:0] addr;
  } stim_t;

  typedef struct {
    int valid, fmt, sub, thaddr, mux, rr, qs, keep, rule;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  stim_t       st = '0;
  logic        valid_o, thaddr_o, lc_tc_mux_o, resync_timer_rst_o;
  logic [1:0]  packet_format_o, packet_f_sync_subformat_o, qual_status_o;
  logic [4:0]  keep_bits_o;
  int          total = 0;
  int          bad = 0;
  int          model_rep = 0;

  always #5 clk = ~clk;

  trdb_priority dut (
    .clk_i                     (clk),
    .rst_ni                    (rst_ni),
    .valid_i                   (st.valid),
    .lc_exception_i            (st.lc_exc),
    .lc_updiscon_i             (st.lc_upd),
    .lc_final_qualified_i      (st.lc_fq),
    .tc_qualified_i            (st.tc_q),
    .tc_exception_i            (st.tc_exc),
    .tc_retired_i              (st.tc_ret),
    .tc_first_qualified_i      (st.tc_fq),
    .tc_privchange_i           (st.tc_priv),
    .tc_gt_max_resync_i        (st.tc_gt),
    .tc_et_max_resync_i        (st.tc_et),
    .tc_branch_map_empty_i     (st.tc_bme),
    .tc_branch_map_full_i      (st.tc_bmf),
    .tc_enc_enabled_i          (st.tc_en),
    .tc_enc_disabled_i         (st.tc_dis),
    .tc_opmode_change_i        (st.tc_opm),
    .nc_exception_i            (st.nc_exc),
    .nc_privchange_i           (st.nc_priv),
    .nc_branch_map_empty_i     (st.nc_bme),
    .nc_qualified_i            (st.nc_q),
    .nc_retired_i              (st.nc_ret),
    .addr_to_compress_i        (st.addr),
    .valid_o                   (valid_o),
    .packet_format_o           (packet_format_o),
    .packet_f_sync_subformat_o (packet_f_sync_subformat_o),
    .thaddr_o                  (thaddr_o),
    .lc_tc_mux_o               (lc_tc_mux_o),
    .resync_timer_rst_o        (resync_timer_rst_o),
    .qual_status_o             (qual_status_o),
    .keep_bits_o               (keep_bits_o)
  );

  // Behavioural reference: pick the winning rule, then derive each output
  function automatic exp_t model(input stim_t s, input int rep);
    exp_t e;
    int   n;
    int   addr_fmt;
    e = '{default: 0};
    n = 1;
    while (n < 32 && s.addr[31-n] == s.addr[31]) n++;
    e.keep = 32 - n;
    addr_fmt = s.tc_bme ? 2 : 1;
    if (!s.valid) e.rule = 0;
    else if (s.tc_en || s.tc_dis || s.tc_opm) e.rule = 1;
    else if (!s.tc_q) e.rule = 0;
    else if (s.lc_exc) e.rule = 3;
    else if (s.tc_fq || s.tc_priv || (s.tc_et && s.tc_bme)) e.rule = 4;
    else if (s.lc_upd) e.rule = 5;
    else if (s.tc_gt && !s.tc_bme) e.rule = 6;
    else if (s.tc_ret && (s.nc_exc || s.nc_priv || !s.nc_q)) e.rule = 7;
    else if (s.tc_bmf) e.rule = 8;
    else e.rule = 0;
    case (e.rule)
      1: begin e.fmt = 3; e.sub = 3; e.qs = s.tc_dis ? (rep != 0 ? 1 : 3) : 0; end
      3: begin e.fmt = 3; e.sub = 1; e.mux = 1; e.rr = 1; e.thaddr = (s.tc_exc && !s.tc_ret) ? 0 : 1; end
      4: begin e.fmt = 3; e.sub = 0; e.mux = 1; e.rr = 1; end
      5, 7: begin e.fmt = addr_fmt; e.mux = 1; end
      6: begin e.fmt = addr_fmt; e.mux = 1; e.rr = 1; end
      8: e.fmt = 1;
      default: ;
    endcase
    e.valid = (e.rule != 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison; also reacts to an asynchronous reset assertion
  always begin
    exp_t e;
    @(negedge clk or negedge rst_ni);
    #1;
    if (!rst_ni) model_rep = 0;
    e = model(st, model_rep);
    chk("m_valid", int'(valid_o), e.valid);
    chk("m_format", int'(packet_format_o), e.fmt);
    chk("m_subformat", int'(packet_f_sync_subformat_o), e.sub);
    chk("m_thaddr", int'(thaddr_o), e.thaddr);
    chk("m_lc_tc_mux", int'(lc_tc_mux_o), e.mux);
    chk("m_resync_rst", int'(resync_timer_rst_o), e.rr);
    chk("m_qual_status", int'(qual_status_o), e.qs);
    chk("m_keep_bits", int'(keep_bits_o), e.keep);
    if (rst_ni) begin
      if (e.rule == 1) model_rep = 0;
      else if (e.rule == 7 && !st.nc_q) model_rep = 1;
    end
  end

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    st = s;
  endtask

  task automatic settle;
    @(negedge clk);
    #2;
  endtask

  function automatic logic pr(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  function automatic stim_t rand_stim;
    stim_t s;
    logic [31:0] tmp;
    int sh;
    s.valid = pr(90);   s.lc_exc = pr(15);  s.lc_upd = pr(20);  s.lc_fq = pr(50);
    s.tc_q = pr(85);    s.tc_exc = pr(30);  s.tc_ret = pr(60);  s.tc_fq = pr(10);
    s.tc_priv = pr(8);  s.tc_gt = pr(20);   s.tc_et = pr(20);   s.tc_bme = pr(50);
    s.tc_bmf = pr(40);  s.tc_en = pr(5);    s.tc_dis = pr(8);   s.tc_opm = pr(5);
    s.nc_exc = pr(20);  s.nc_priv = pr(15); s.nc_bme = pr(50);  s.nc_q = pr(60);
    s.nc_ret = pr(50);
    tmp = $urandom;
    sh = $urandom_range(0, 32);
    s.addr = (sh == 32) ? {32{tmp[31]}} : 32'($signed(tmp) >>> sh);
    return s;
  endfunction

  initial begin
    stim_t s;
    // Reset state
    #12;
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_qual", int'(qual_status_o), 0);
    chk("reset_keep", int'(keep_bits_o), 0);
    @(posedge clk); #1; rst_ni = 1'b1;

    s = '0; s.valid = 1; s.tc_q = 1; s.tc_fq = 1; s.nc_q = 1;
    drive(s); settle;
    chk("sync_valid", int'(valid_o), 1);
    chk("sync_format", int'(packet_format_o), 3);
    chk("sync_sub", int'(packet_f_sync_subformat_o), 0);
    chk("sync_mux", int'(lc_tc_mux_o), 1);
    chk("sync_resync", int'(resync_timer_rst_o), 1);

    s = '0; s.valid = 1; s.tc_q = 1; s.lc_exc = 1; s.tc_exc = 1; s.nc_q = 1;
    drive(s); settle;
    chk("trap_format", int'(packet_format_o), 3);
    chk("trap_sub", int'(packet_f_sync_subformat_o), 1);
    chk("trap_thaddr0", int'(thaddr_o), 0);
    s.tc_ret = 1;
    drive(s); settle;
    chk("trap_thaddr1", int'(thaddr_o), 1);

    s = '0; s.valid = 1; s.tc_q = 1; s.lc_upd = 1; s.nc_q = 1;
    drive(s); settle;
    chk("updiscon_f1", int'(packet_format_o), 1);
    chk("updiscon_mux", int'(lc_tc_mux_o), 1);
    s.tc_bme = 1;
    drive(s); settle;
    chk("updiscon_f2", int'(packet_format_o), 2);

    // Qualification ends after a retire: rep flag is captured then reported
    s = '0; s.valid = 1; s.tc_q = 1; s.tc_ret = 1;
    drive(s); settle;
    chk("rep_a_valid", int'(valid_o), 1);
    chk("rep_a_format", int'(packet_format_o), 1);
    s = '0; s.valid = 1; s.tc_dis = 1;
    drive(s); settle;
    chk("rep_b_format", int'(packet_format_o), 3);
    chk("rep_b_sub", int'(packet_f_sync_subformat_o), 3);
    chk("rep_b_qual", int'(qual_status_o), 1);
    // Reset mid-cycle must drop the rep flag without a clock
    #1; rst_ni = 1'b0; #1;
    chk("async_rst_qual", int'(qual_status_o), 3);
    @(posedge clk); #1; rst_ni = 1'b1;
    settle;
    chk("ntr_qual", int'(qual_status_o), 3);

    s = '0; s.addr = 32'h0000_0000; drive(s); settle; chk("keep_zero", int'(keep_bits_o), 0);
    s.addr = 32'hFFFF_FFFF; drive(s); settle; chk("keep_ones", int'(keep_bits_o), 0);
    s.addr = 32'h0000_FFFF; drive(s); settle; chk("keep_half", int'(keep_bits_o), 16);
    s.addr = 32'h4000_0000; drive(s); settle; chk("keep_max", int'(keep_bits_o), 31);

    s = '1; s.valid = 0;
    drive(s); settle;
    chk("novalid_valid", int'(valid_o), 0);
    chk("novalid_format", int'(packet_format_o), 0);
    s = '0; s.valid = 1; s.lc_exc = 1; s.tc_bmf = 1; s.tc_ret = 1;
    drive(s); settle;
    chk("unqual_valid", int'(valid_o), 0);

    // Randomized run with occasional mid-cycle resets
    for (int i = 0; i < 4000; i++) begin
      s = rand_stim();
      @(posedge clk); #1;
      st = s;
      rst_ni = 1'b1;
      if ($urandom_range(0, 99) == 0) begin
        #2; rst_ni = 1'b0;
      end
    end
    @(posedge clk); #1; rst_ni = 1'b1;
    settle;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
